jk_switch_debouncer: RTL
========================

# jk_switch_debouncer

Conditioning stage placed directly upstream of the JK flip-flop block. It takes the raw, asynchronous J and K switch inputs, synchronises them into the clock domain, and filters out bounce. It delivers clean, glitch-free J/K levels to the flip-flop, together with one-cycle rising-edge strobes and a toggle-mode indicator.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive synchronised cycles a new level must persist before it is accepted. Legal range 2..255.
- CNT_WIDTH, default 8: width of each debounce counter. Must satisfy DEBOUNCE_CYCLES <= 2^CNT_WIDTH - 1.

Ports:
- input_clock1_clk_1, input, 1: single system clock; all state updates on its rising edge.
- input_input_switch2__reset_2, input, 1: asynchronous, active-low reset; clears all state immediately.
- input_input_switch3_j_3, input, 1: raw J switch, asynchronous to the clock, may bounce.
- input_input_switch4_k_4, input, 1: raw K switch, asynchronous to the clock, may bounce.
- output_led1_j_5, output, 1: debounced J level; feeds the flip-flop J input.
- output_led2_k_6, output, 1: debounced K level; feeds the flip-flop K input.
- output_led3_j_rise_7, output, 1: one-cycle strobe when debounced J goes 0->1.
- output_led4_k_rise_8, output, 1: one-cycle strobe when debounced K goes 0->1.
- output_led5_toggle_9, output, 1: high while both debounced J and K are 1 (flip-flop toggle mode).

## Operation
- Two identical, independent channels (J, K). Each channel contains:
  - a 2-FF synchroniser (s1, s2);
  - a CNT_WIDTH-bit counter;
  - a stable register;
  - a rise-strobe register.
- Synchroniser: s1 <= raw; s2 <= s1.
- Counter FSM per channel, comparing s2 against stable:
  - s2 == stable: counter <= 0 (IDLE). Any mismatch shorter than the threshold is discarded.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1 (COUNTING).
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0 (ACCEPT).
- Rise strobe: set to 1 on the ACCEPT edge when s2 == 1; cleared on every other edge. Never high for two consecutive cycles. Falling acceptance produces no strobe.
- Toggle output: registered. On every edge it takes the AND of the next-state J stable value and the next-state K stable value, so it changes on the same edge as the later of the two stable outputs.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Channels share no state. Simultaneous J and K transitions are accepted on the same edge when their timing is identical.

## Timing
- Reset values, applied asynchronously while reset is low: s1, s2, stable, counter, strobes and toggle all 0, so every output is 0.
- Reset asserted mid-count: the count is lost and outputs drop to 0 without waiting for a clock edge.
- After reset release: a raw input already at 1 still needs the full latency before it is accepted.
- Latency: raw level settled before edge E0 -> s2 valid after E1 -> stable output changes after edge E(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES=4: output changes after the 6th rising edge counted from E0.
  - The rise strobe is high in the same cycle as the new stable level, for one cycle only.
- Glitch rejection: an s2 mismatch lasting DEBOUNCE_CYCLES-1 cycles or fewer leaves the outputs unchanged.
- Bounce mid-count: an s2 mismatch that returns to the stable value for even one cycle restarts the count from 0.
- Throughput: a channel can accept a new level at most once every DEBOUNCE_CYCLES cycles.

## Test plan
- Reset: hold reset low with raw J=K=1 -> all five outputs 0. Release reset, keep J=1 -> output_led1_j_5 rises after edge E5 (D=4, with E0 the first edge after release), output_led3_j_rise_7 is high for exactly that one cycle, and output_led2_k_6 rises after the same edge.
- Bounce: raw J pattern 1,0,1,0,1 (one cycle each), then steady 1 -> no output change during the bounce. J is accepted 6 edges after the final 0->1, with a single strobe.
- Glitch: J=0 stable, then a 3-cycle J=1 pulse (D=4) -> output_led1_j_5 stays 0 and the strobe stays 0. A 4-cycle pulse -> J goes 1 and the strobe fires once.
- Toggle: J and K raised 2 cycles apart, both held -> output_led5_toggle_9 rises on the same edge as the later of J or K. Dropping K -> toggle falls on the same edge K falls, and no strobe fires on the fall.
- Reset mid-count: J at 1 with its counter at 2, assert reset between edges -> all outputs 0 immediately. After release, J needs the full 6 edges to be accepted.
- Parameter sweep: DEBOUNCE_CYCLES=2 and DEBOUNCE_CYCLES=255 -> latency is D+2 edges in both cases, and the counter never exceeds D-1.

Source files
------------

// File: rtl/jk_switch_debouncer.sv
// Switch conditioning for the JK flip-flop: 2-FF synchronisers, per-channel debounce
// counters, rise strobes and a registered toggle-mode indicator.
module jk_db_channel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic stable_o,
   output logic stable_d_o,
   output logic rise_o
);

   // ACC_RISE doubles as the registered rise strobe: it is only ever held for one cycle.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COUNTING = 2'b01,
      ACC_FALL = 2'b10,
      ACC_RISE = 2'b11
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 s1_q, s2_q;
   logic                 stable_q, stable_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   state_t               state_q, state_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      state_d  = IDLE;
      if (s2_q != stable_q) begin
         if (cnt_q == LAST) begin
            stable_d = s2_q;
            state_d  = s2_q ? ACC_RISE : ACC_FALL;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = COUNTING;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         state_q  <= IDLE;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   assign stable_o   = stable_q;
   assign stable_d_o = stable_d;
   assign rise_o     = (state_q == ACC_RISE);

endmodule

module jk_switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic input_clock1_clk_1,
   input  logic input_input_switch2__reset_2,
   input  logic input_input_switch3_j_3,
   input  logic input_input_switch4_k_4,
   output logic output_led1_j_5,
   output logic output_led2_k_6,
   output logic output_led3_j_rise_7,
   output logic output_led4_k_rise_8,
   output logic output_led5_toggle_9
);

   logic j_stable_d, k_stable_d;
   logic toggle_q, toggle_d;

   jk_db_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_j (
      .clk_i     (input_clock1_clk_1),
      .rst_ni    (input_input_switch2__reset_2),
      .raw_i     (input_input_switch3_j_3),
      .stable_o  (output_led1_j_5),
      .stable_d_o(j_stable_d),
      .rise_o    (output_led3_j_rise_7)
   );

   jk_db_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_k (
      .clk_i     (input_clock1_clk_1),
      .rst_ni    (input_input_switch2__reset_2),
      .raw_i     (input_input_switch4_k_4),
      .stable_o  (output_led2_k_6),
      .stable_d_o(k_stable_d),
      .rise_o    (output_led4_k_rise_8)
   );

   // Built from next-state levels so toggle moves on the same edge as the later channel.
   assign toggle_d = j_stable_d & k_stable_d;

   always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch2__reset_2) begin
      if (!input_input_switch2__reset_2) toggle_q <= 1'b0;
      else                               toggle_q <= toggle_d;
   end

   assign output_led5_toggle_9 = toggle_q;

endmodule
